// File: rtl/mult_pkg.sv
// Shared FSM encodings, Booth digit type and iteration-count helper for the
// sequential radix-4 Booth multiplier.
package mult_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t BUSY = 2'd1;
  localparam state_t DONE = 2'd2;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_e;

  // Operands are extended by two bits, so WIDTH+2 bits need (WIDTH+2)/2 digits.
  function automatic int booth_iter(input int width);
    return (width / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Radix-4 Booth recoding of the multiplier triplet {q[i+1], q[i], q[i-1]}.
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0]   triplet_i,
  output booth_digit_e digit_o
);

  // Standard radix-4 digit table; 000 and 111 contribute nothing.
  always_comb begin
    case (triplet_i)
      3'b001, 3'b010: digit_o = POS1;
      3'b011:         digit_o = POS2;
      3'b100:         digit_o = NEG2;
      3'b101, 3'b110: digit_o = NEG1;
      default:        digit_o = ZERO;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand finishes one cycle after accept.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   S
);

  localparam int ITER  = booth_iter(WIDTH);
  localparam int MW    = WIDTH + 2;
  localparam int PW    = WIDTH + 4;
  localparam int CNT_W = $clog2(ITER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ITER - 1);

  if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_width_check
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_t             state_q, state_d;
  logic [MW-1:0]      m_q, m_d;
  logic [MW-1:0]      q_q, q_d;
  logic               qm1_q, qm1_d;
  logic [PW-1:0]      p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] s_q, s_d;

  logic [MW-1:0]      a_ext_s, b_ext_s;
  logic [PW-1:0]      m_ext_s, addend_s, p_sum_s, p_shift_s;
  logic [MW-1:0]      q_shift_s;
  booth_digit_e       digit_s;

  // The extra two bits make the unsigned full-scale product exact.
  assign a_ext_s = {{2{signed_mode & A[WIDTH-1]}}, A};
  assign b_ext_s = {{2{signed_mode & B[WIDTH-1]}}, B};
  assign m_ext_s = {{2{m_q[MW-1]}}, m_q};

  booth_recoder u_recoder (
    .triplet_i ({q_q[1], q_q[0], qm1_q}),
    .digit_o   (digit_s)
  );

  // Selected Booth partial product, sign-extended to the accumulator width.
  always_comb begin
    case (digit_s)
      POS1:    addend_s = m_ext_s;
      POS2:    addend_s = {m_ext_s[PW-2:0], 1'b0};
      NEG1:    addend_s = -m_ext_s;
      NEG2:    addend_s = -{m_ext_s[PW-2:0], 1'b0};
      default: addend_s = {PW{1'b0}};
    endcase
  end

  assign p_sum_s   = p_q + addend_s;
  assign p_shift_s = {{2{p_sum_s[PW-1]}}, p_sum_s[PW-1:2]};
  assign q_shift_s = {p_sum_s[1:0], q_q[MW-1:2]};

  // Next-state and datapath control for IDLE -> BUSY -> DONE.
  always_comb begin
    state_d     = state_q;
    m_d         = m_q;
    q_d         = q_q;
    qm1_d       = qm1_q;
    p_d         = p_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    s_d         = s_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = BUSY;
          qm1_d   = 1'b0;
          p_d     = {PW{1'b0}};
`ifdef BOOTH_ZERO_SKIP_EN
          // A zeroed datapath run for a single step yields S = 0 one cycle later.
          if ((A == {WIDTH{1'b0}}) || (B == {WIDTH{1'b0}})) begin
            m_d   = {MW{1'b0}};
            q_d   = {MW{1'b0}};
            cnt_d = CNT_LAST;
          end else begin
            m_d   = a_ext_s;
            q_d   = b_ext_s;
            cnt_d = {CNT_W{1'b0}};
          end
`else
          m_d   = a_ext_s;
          q_d   = b_ext_s;
          cnt_d = {CNT_W{1'b0}};
`endif
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        p_d   = p_shift_s;
        q_d   = q_shift_s;
        qm1_d = q_q[1];
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          s_d         = {p_shift_s[WIDTH-3:0], q_shift_s};
        end else begin
          state_d = BUSY;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
    in_ready_d = (state_d == IDLE);
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      m_q         <= {MW{1'b0}};
      q_q         <= {MW{1'b0}};
      qm1_q       <= 1'b0;
      p_q         <= {PW{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= {(2*WIDTH){1'b0}};
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      q_q         <= q_d;
      qm1_q       <= qm1_d;
      p_q         <= p_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;

endmodule

// File: doc/booth_seq_multiplier.md
Name: booth_seq_multiplier

Overview:
- Iterative radix-4 Booth multiplier: the area-reduced, parametrised successor to the flat combinational multiplier64.
- Accepts WIDTH-bit operands over a valid/ready handshake and retires one Booth digit per clock.
- Returns the full 2*WIDTH-bit product over a valid/ready handshake.
- Supports signed and unsigned operation per transaction; sits in the arithmetic datapath next to the adder/multiplier family.

Parameters:
- WIDTH, 64, operand width in bits; must be even and >= 4 (elaboration-time assertion).
- ITER, WIDTH/2+1, Booth iterations per product; derived, not to be overridden.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept operands.
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  S holds a completed product.
- out_ready  input  1  consumer accepts S.
- S  output  2*WIDTH  product.

Behaviour:
- Reset (async assert, sync release): state IDLE, in_ready=1, out_valid=0, S=0, all internal registers 0.
- Reset asserted mid-operation aborts the transaction; no partial result is ever presented.
- State machine: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - Accept when in_valid&&in_ready.
  - Latch multiplicand M = A extended to WIDTH+2 bits (sign-extended if signed_mode, else zero-extended).
  - Latch multiplier Q = B extended to WIDTH+2 bits the same way, with implicit q[-1]=0.
  - Clear accumulator P and counter; go to BUSY.
- BUSY:
  - in_ready=0.
  - Each cycle: recode triplet {Q[1],Q[0],q-1} to a digit in {0,+M,+2M,-M,-2M}.
  - Add the digit to the upper part of P (width WIDTH+4, sign-extended arithmetic).
  - Arithmetic-shift {P,Q,q-1} right by 2.
  - counter++.
  - After ITER iterations go to DONE, with S = low 2*WIDTH bits of the combined product register.
- DONE:
  - out_valid=1; S stable.
  - On out_valid&&out_ready: out_valid=0, go to IDLE.
  - Back-pressure holds DONE indefinitely with S unchanged.
- Latency: accept edge to out_valid high = ITER cycles (33 for WIDTH=64).
- Throughput: one product per ITER+2 cycles. There is no overlap: in_ready=0 in BUSY and DONE.
- in_valid, A, B and signed_mode are ignored when in_ready=0.
- Width rule: the result is exact mod 2^(2*WIDTH) in both modes. The unsigned full-scale case is exact because of the 2-bit extension.
- S retains its last product after the handshake and until the next DONE; it is cleared only by reset.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined: if A==0 or B==0 at accept, go directly to DONE with S=0; out_valid is high 1 cycle after accept.
- Not defined: every transaction takes the full ITER cycles regardless of operand values.

Decomposition:
- Package mult_pkg holds:
  - the state enum (IDLE, BUSY, DONE);
  - the Booth digit enum (ZERO, POS1, POS2, NEG1, NEG2);
  - the localparam helper for ITER.
- One sub-module, booth_recoder: combinational, maps a 3-bit triplet to a digit enum.
- The top level builds the ±M/±2M operand from the digit enum.

Test Plan:
- Unsigned, A=0, B=0 -> out_valid exactly 33 cycles after accept (1 cycle with BOOTH_ZERO_SKIP_EN), S=0.
- Unsigned, A=64'h4f704b31d58f02dd, B=0 -> S=0.
  - Signed, A=64'hc04a141011a31c0b, B=1 -> S=128'hffffffffffffffffc04a141011a31c0b.
  - Same operands unsigned -> S=128'h0000000000000000c04a141011a31c0b.
- A=B=64'hffffffffffffffff:
  - unsigned -> S=128'hfffffffffffffffe0000000000000001;
  - signed -> S=128'h1.
- Random signed and unsigned pairs, including A=64'h750374286c58462a, B=64'hdcdf7b83db0a62f1, checked against a behavioural A*B reference.
  - out_ready held low 10 cycles -> S stable and in_ready=0 throughout.
  - in_valid pulsed while BUSY -> ignored.
- Assert rst_n low mid-BUSY (counter=12) -> out_valid=0 and S=0 immediately, in_ready=1 after release.
  - The next transaction (3*5 unsigned) -> S=15.
